alu_bitserial_seq: RTL and testbench

ALU_BITSERIAL_SEQ -- requirements
Module: alu_bitserial_seq

---
 rtl/alu_pkg.sv | 5 +
 rtl/bitser_shreg.sv | 26 ++
 rtl/alu_bitserial_seq.sv | 66 ++++++
 tb/tb_alu_bitserial_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state type and default operand width for the bit-serial ALU sequencer.
package alu_pkg;
   localparam int ALU_WIDTH = 8;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bitser_shreg.sv
// bitser_shreg: parallel-load register that shifts right, taking sin into the MSB.
module bitser_shreg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic         sin,
   input  logic [W-1:0] din,
   output logic [W-1:0] q
);
   logic [W-1:0] q_q, q_d, sh;
   generate
      if (W == 1) begin : g_one
         assign sh = sin;
      end else begin : g_wide
         assign sh = {sin, q_q[W-1:1]};
      end
   endgenerate
   always_comb q_d = load ? din : shift ? sh : q_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) q_q <= '0;
      else q_q <= q_d;
   assign q = q_q;
endmodule

// File: rtl/alu_bitserial_seq.sv
// alu_bitserial_seq: feeds two operands LSB-first through an external 1-bit ALU and
// reassembles the result plus an all-bits-zero flag.
module alu_bitserial_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [1:0]       alu_ctrl,
   output logic             alu_in_1,
   output logic             alu_in_2,
   input  logic             alu_data_out,
   input  logic             alu_zero_flag
);
   localparam int CW = $clog2(WIDTH + 1);
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0] op_q, op_d;
   logic zero_q, zero_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic shift, accept, last, unused_bits;
   assign shift  = state_q == SHIFT;
   assign accept = !shift && start;
   assign last   = cnt_q == CW'(WIDTH - 1);
   always_comb begin
      state_d = accept ? SHIFT : shift ? (last ? DONE : SHIFT) : IDLE;
      cnt_d   = accept ? '0 : shift ? cnt_q + CW'(1) : cnt_q;
      op_d    = accept ? op : op_q;
      zero_d  = accept ? 1'b1 : shift ? zero_q & alu_zero_flag : zero_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         zero_q  <= zero_d;
      end
   bitser_shreg #(.W(WIDTH)) u_a (.clk(clk), .rst(rst), .load(accept), .shift(shift),
                                  .sin(1'b0), .din(opa), .q(a_q));
   bitser_shreg #(.W(WIDTH)) u_b (.clk(clk), .rst(rst), .load(accept), .shift(shift),
                                  .sin(1'b0), .din(opb), .q(b_q));
   // Result fills from the top, so after WIDTH shifts bit 0 holds the first ALU bit.
   bitser_shreg #(.W(WIDTH)) u_r (.clk(clk), .rst(rst), .load(accept), .shift(shift),
                                  .sin(alu_data_out), .din('0), .q(result));
   assign unused_bits = ^{a_q, b_q};
   assign busy     = shift;
   assign done     = state_q == DONE;
   assign zero     = zero_q;
   assign alu_in_1 = shift & a_q[0];
   assign alu_in_2 = shift & b_q[0];
   assign alu_ctrl = shift ? op_q : 2'b00;
endmodule

// File: tb/tb_alu_bitserial_seq.sv
// tb_alu_bitserial_seq: randomized and directed checks of the bit-serial ALU sequencer
// against a transaction-level model using an AND-gate ALU.
module tb_alu_bitserial_seq;
   localparam int W = 8;
   logic clk = 0, rst = 0, start = 0;
   logic [1:0] op = 0;
   logic [W-1:0] opa = 0, opb = 0, result;
   logic busy, done, zero, alu_in_1, alu_in_2, alu_data_out, alu_zero_flag;
   logic [1:0] alu_ctrl;
   logic start1 = 0, opa1 = 0, opb1 = 0, result1;
   logic busy1, done1, zero1, in1_1, in2_1, dout1, zf1;
   logic [1:0] ctrl1;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   assign alu_data_out  = alu_in_1 & alu_in_2;
   assign alu_zero_flag = ~alu_data_out;
   assign dout1 = in1_1 & in2_1;
   assign zf1   = ~dout1;

   alu_bitserial_seq #(.WIDTH(W)) u8 (
      .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
      .busy(busy), .done(done), .result(result), .zero(zero), .alu_ctrl(alu_ctrl),
      .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_data_out(alu_data_out),
      .alu_zero_flag(alu_zero_flag));

   alu_bitserial_seq #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .op(2'b00), .opa(opa1), .opb(opb1),
      .busy(busy1), .done(done1), .result(result1), .zero(zero1), .alu_ctrl(ctrl1),
      .alu_in_1(in1_1), .alu_in_2(in2_1), .alu_data_out(dout1), .alu_zero_flag(zf1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: an accepted op occupies W cycles, then one done cycle.
   logic [W-1:0] ma = 0, mb = 0;
   logic [1:0] mop = 0;
   int m_idx = 0;
   logic m_busy = 0, m_done = 0, m_have = 0;
   always @(posedge clk or posedge rst)
      if (rst) begin
         m_busy <= 0; m_done <= 0; m_have <= 0; m_idx <= 0;
      end else if (!m_busy && start) begin
         ma <= opa; mb <= opb; mop <= op; m_idx <= 0; m_busy <= 1; m_done <= 0;
      end else if (m_busy) begin
         m_idx  <= m_idx + 1;
         m_busy <= m_idx != W - 1;
         m_done <= m_idx == W - 1;
         if (m_idx == W - 1) m_have <= 1;
      end else m_done <= 0;

   always @(negedge clk) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("alu_in_1", alu_in_1, m_busy ? ma[m_idx] : 1'b0);
      chk("alu_in_2", alu_in_2, m_busy ? mb[m_idx] : 1'b0);
      chk("alu_ctrl", alu_ctrl, m_busy ? mop : 2'b00);
      if (!m_busy) begin
         chk("result", result, m_have ? (ma & mb) : '0);
         chk("zero", zero, m_have ? ((ma & mb) == 0) : 1'b0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [7:0] a, input logic [7:0] b,
                      output int lat, output int nb, output logic [7:0] bits);
      opa = a; opb = b; op = 2'($urandom_range(0, 3)); start = 1;
      nb = 0; bits = 0;
      tick();
      start = 0; lat = 1;
      while (!done && lat < 40) begin
         if (busy) begin
            bits = {alu_in_1, bits[7:1]};
            nb++;
         end
         tick();
         lat++;
      end
      chk("done_wait", done, 1);
   endtask

   initial begin
      int lat, nb, nd, n;
      logic [7:0] bits;
      #1 rst = 1;
      #20;
      @(posedge clk);
      #1 rst = 0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 0);
      tick();
      run(8'hA5, 8'h3C, lat, nb, bits);
      chk("a5_latency", lat, 9);
      chk("a5_in1_bits", bits, 8'hA5);
      chk("a5_busy_cycles", nb, 8);
      chk("a5_result", result, 8'h24);
      chk("a5_zero", zero, 0);
      tick();
      run(8'hF0, 8'h0F, lat, nb, bits);
      chk("f0_result", result, 8'h00);
      chk("f0_zero", zero, 1);
      chk("f0_busy_cycles", nb, 8);
      tick();
      opa = 8'hA5; opb = 8'h3C; start = 1;
      tick();
      start = 0;
      tick(); tick();
      opa = 8'hFF; opb = 8'hFF; start = 1;
      tick();
      start = 0;
      nd = 0;
      repeat (16) begin
         if (done) begin
            nd++;
            chk("mid_result", result, 8'h24);
         end
         tick();
      end
      chk("mid_done_pulses", nd, 1);
      run(8'hA5, 8'h3C, lat, nb, bits);
      opa = 8'hFF; opb = 8'hFF; start = 1;
      tick();
      chk("b2b_busy", busy, 1);
      start = 0;
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chk("b2b_latency", n, 8);
      chk("b2b_result", result, 8'hFF);
      chk("b2b_zero", zero, 0);
      tick();
      opa = 8'hAA; opb = 8'hF3; start = 1;
      tick();
      start = 0;
      repeat (3) tick();
      #2 rst = 1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_result", result, 0);
      chk("arst_zero", zero, 0);
      @(posedge clk);
      #1 rst = 0;
      nd = 0;
      repeat (12) begin
         if (done) nd++;
         tick();
      end
      chk("arst_no_done", nd, 0);
      run(8'hAA, 8'hF3, lat, nb, bits);
      chk("post_rst_result", result, 8'hA2);
      chk("post_rst_zero", zero, 0);
      tick();
      opa1 = 1; opb1 = 1; start1 = 1;
      tick();
      start1 = 0; n = 1;
      while (!done1 && n < 10) begin
         tick();
         n++;
      end
      chk("w1_latency", n, 2);
      chk("w1_result", result1, 1);
      chk("w1_zero", zero1, 0);
      opa1 = 1; opb1 = 0; start1 = 1;
      tick();
      start1 = 0;
      tick();
      chk("w1b_done", done1, 1);
      chk("w1b_result", result1, 0);
      chk("w1b_zero", zero1, 1);
      repeat (800) begin
         start = $urandom_range(0, 2) == 0;
         opa = 8'($urandom); opb = 8'($urandom); op = 2'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            opb = opa ^ 8'hFF;
         end
         tick();
         if ($urandom_range(0, 149) == 0) begin
            #1 rst = 1;
            #1 rst = 0;
         end
      end
      start = 0;
      repeat (12) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
